// File: rtl/debug_display_mux.sv
// Debug viewer: selects a 16-bit slice of one debug channel and shows it on the
// LEDs and a 4-digit multiplexed seven-segment display. It supports a freeze mode
// and per-channel sticky event flags shown on the decimal point.
module debug_display_mux #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned CH_WIDTH   = 32,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned WSEL_W     = 2,
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [SEL_W-1:0]           sel,
    input  logic [WSEL_W-1:0]          word_sel,
    input  logic                       hold,
    input  logic                       sticky_clr,
    output logic [15:0]                led,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [3:0]                 an
);

    localparam int unsigned DIV_RAW = CLOCK_FREQ / (SCAN_HZ * 4);
    localparam int unsigned DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    // Channel is zero-padded up to the full slice-addressable width so that
    // slices past CH_WIDTH read as zero.
    localparam int unsigned NWORD_W = 16 * (2 ** WSEL_W);
    localparam int unsigned PAD_W   = (CH_WIDTH > NWORD_W) ? CH_WIDTH : NWORD_W;

    // Synchroniser stages for the asynchronous switch inputs
    logic [SEL_W-1:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [WSEL_W-1:0] wsel_s1_q, wsel_s1_d, wsel_s2_q, wsel_s2_d;
    logic              hold_s1_q, hold_s1_d, hold_s2_q, hold_s2_d;
    logic              clr_s1_q, clr_s1_d, clr_s2_q, clr_s2_d, clr_s3_q, clr_s3_d;

    logic [15:0]       disp_word_q, disp_word_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              started_q, started_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;

    logic [CH_WIDTH-1:0] ch_sel;
    logic [PAD_W-1:0]    ch_pad;
    logic [15:0]         mux_word;
    logic                clr_edge;
    logic                wrap;
    logic                sel_flag;

    // Active-low hex encoding, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Channel/slice mux and sticky flag of the selected channel
    always_comb begin
        ch_sel   = '0;
        sel_flag = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(sel_s2_q) == k) begin
                ch_sel   = ch_data[k*CH_WIDTH +: CH_WIDTH];
                sel_flag = sticky_q[k];
            end
        end
        ch_pad   = PAD_W'(ch_sel);
        mux_word = ch_pad[32'(wsel_s2_q)*16 +: 16];
    end

    // Next-state for synchronisers, display word and sticky flags
    always_comb begin
        sel_s1_d    = sel;
        sel_s2_d    = sel_s1_q;
        wsel_s1_d   = word_sel;
        wsel_s2_d   = wsel_s1_q;
        hold_s1_d   = hold;
        hold_s2_d   = hold_s1_q;
        clr_s1_d    = sticky_clr;
        clr_s2_d    = clr_s1_q;
        clr_s3_d    = clr_s2_q;
        clr_edge    = clr_s2_q & ~clr_s3_q;
        disp_word_d = hold_s2_q ? disp_word_q : mux_word;
        // A new event wins over a clear in the same cycle
        sticky_d    = (sticky_q & ~{NUM_CH{clr_edge}}) | ch_valid;
    end

    // Next-state for digit scan; outputs reload on each wrap and on the first
    // cycle after reset so digit 0 appears immediately.
    always_comb begin
        wrap      = (cnt_q == CNT_W'(DIV - 1));
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        started_d = 1'b1;
        seg_d     = seg_q;
        dp_d      = dp_q;
        an_d      = an_q;
        if (wrap || !started_q) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = hex7(disp_word_q[{idx_d, 2'b00} +: 4]);
            dp_d  = ~((idx_d == 2'd0) & sel_flag);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            wsel_s1_q   <= '0;
            wsel_s2_q   <= '0;
            hold_s1_q   <= 1'b0;
            hold_s2_q   <= 1'b0;
            clr_s1_q    <= 1'b0;
            clr_s2_q    <= 1'b0;
            clr_s3_q    <= 1'b0;
            disp_word_q <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            started_q   <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            wsel_s1_q   <= wsel_s1_d;
            wsel_s2_q   <= wsel_s2_d;
            hold_s1_q   <= hold_s1_d;
            hold_s2_q   <= hold_s2_d;
            clr_s1_q    <= clr_s1_d;
            clr_s2_q    <= clr_s2_d;
            clr_s3_q    <= clr_s3_d;
            disp_word_q <= disp_word_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign led = disp_word_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_debug_display_mux.sv
// Bench for debug_display_mux: directed and random stimulus, expected outputs
// from a behavioural model pushed into a scoreboard queue, checked by a monitor.
module tb_debug_display_mux;

    localparam int NUM_CH = 4;
    localparam int DIV    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] ch_data;
    logic [95:0]  ch_data24;
    logic [3:0]   ch_valid;
    logic [2:0]   sel;
    logic [1:0]   word_sel;
    logic         hold;
    logic         sticky_clr;
    logic [15:0]  led, led24;
    logic [6:0]   seg, seg24;
    logic         dp, dp24;
    logic [3:0]   an, an24;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch24
        assign ch_data24[k*24 +: 24] = ch_data[k*32 +: 24];
    end

    debug_display_mux #(
        .NUM_CH(4), .CH_WIDTH(32), .SEL_W(3), .WSEL_W(2), .CLOCK_FREQ(400), .SCAN_HZ(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid), .sel(sel),
        .word_sel(word_sel), .hold(hold), .sticky_clr(sticky_clr),
        .led(led), .seg(seg), .dp(dp), .an(an)
    );

    debug_display_mux #(
        .NUM_CH(4), .CH_WIDTH(24), .SEL_W(3), .WSEL_W(2), .CLOCK_FREQ(400), .SCAN_HZ(10)
    ) dut24 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data24), .ch_valid(ch_valid), .sel(sel),
        .word_sel(word_sel), .hold(hold), .sticky_clr(sticky_clr),
        .led(led24), .seg(seg24), .dp(dp24), .an(an24)
    );

    typedef struct {
        logic [15:0] led;
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  an;
        logic [15:0] led24;
    } exp_t;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] wsel;
        logic       hold;
        logic       clr;
    } sample_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [6:0]  enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sample_t     past [4];          // past[d] = switch sample before the edge d edges ago
    logic [15:0] m_disp32, m_disp24;
    logic [3:0]  m_sticky;
    int          n_since;           // edges since reset release
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [3:0]  m_an;

    function automatic logic [15:0] pick(input logic [127:0] d, input int w, input int s,
                                         input int ws);
        logic [127:0] ch;
        if (s >= NUM_CH || ws * 16 >= w) return 16'h0;
        ch = (d >> (s * 32)) & ((128'd1 << w) - 128'd1);
        ch = ch >> (ws * 16);
        return ch[15:0];
    endfunction

    // Predict the outputs after the coming edge, queue them, then advance one cycle
    task automatic step();
        exp_t    e;
        sample_t cur;
        int      idx;
        logic    flag;
        cur = '{sel: sel, wsel: word_sel, hold: hold, clr: sticky_clr};
        if (!rst_n) begin
            for (int d = 0; d < 4; d++) past[d] = '0;
            m_disp32 = '0;
            m_disp24 = '0;
            m_sticky = '0;
            n_since  = 0;
            m_seg    = 7'h7F;
            m_dp     = 1'b1;
            m_an     = 4'hF;
        end else begin
            for (int d = 3; d > 0; d--) past[d] = past[d-1];
            past[0] = cur;
            n_since++;
            idx = (n_since / DIV) % 4;
            if (n_since == 1 || n_since % DIV == 0) begin
                flag = 1'b0;
                if (int'(past[2].sel) < NUM_CH) flag = m_sticky[past[2].sel[1:0]];
                m_seg = enc[(m_disp32 >> (idx * 4)) & 16'hF];
                m_an  = ~(4'b0001 << idx);
                m_dp  = !(idx == 0 && flag);
            end
            if (!past[2].hold) begin
                m_disp32 = pick(ch_data, 32, int'(past[2].sel), int'(past[2].wsel));
                m_disp24 = pick(ch_data, 24, int'(past[2].sel), int'(past[2].wsel));
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k]) m_sticky[k] = 1'b1;
                else if (past[2].clr && !past[3].clr) m_sticky[k] = 1'b0;
            end
        end
        e.led   = m_disp32;
        e.led24 = m_disp24;
        e.seg   = m_seg;
        e.dp    = m_dp;
        e.an    = m_an;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic rand_inputs();
        ch_data    = {$urandom, $urandom, $urandom, $urandom};
        ch_valid   = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        sel        = 3'($urandom_range(0, 7));
        word_sel   = 2'($urandom_range(0, 3));
        hold       = ($urandom_range(0, 9) == 0);
        sticky_clr = ($urandom_range(0, 7) == 0) ? ~sticky_clr : sticky_clr;
    endtask

    // Monitor: compares DUT outputs against the queued prediction every cycle
    exp_t got;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            got = q.pop_front();
            chk("led", led, got.led);
            chk("seg", 16'(seg), 16'(got.seg));
            chk("dp", 16'(dp), 16'(got.dp));
            chk("an", 16'(an), 16'(got.an));
            chk("led24", led24, got.led24);
        end
    end

    initial begin
        rst_n      = 1'b0;
        sticky_clr = 1'b0;
        rand_inputs();
        #2;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
        end
        rst_n      = 1'b1;
        ch_data    = '0;
        ch_valid   = '0;
        sel        = 3'd0;
        word_sel   = 2'd0;
        hold       = 1'b0;
        sticky_clr = 1'b0;
        run(2);
        // Select and slice
        ch_data[64 +: 32] = 32'hDEADBEEF;
        sel = 3'd2;
        run(6);
        word_sel = 2'd1;
        run(6);
        // Out-of-range selects
        sel = 3'd5;
        run(5);
        sel = 3'd2;
        word_sel = 2'd2;
        run(5);
        word_sel = 2'd1;
        run(5);
        word_sel = 2'd0;
        run(5);
        // Freeze
        hold = 1'b1;
        run(3);
        ch_data[64 +: 32] = 32'h00001234;
        run(20);
        hold = 1'b0;
        run(5);
        // Full scan cycle
        run(45);
        // Sticky flag set, set-vs-clear, clear
        ch_valid[2] = 1'b1;
        step();
        ch_valid = '0;
        run(45);
        sticky_clr  = 1'b1;
        ch_valid[2] = 1'b1;
        run(4);
        ch_valid = '0;
        run(45);
        sticky_clr = 1'b0;
        run(3);
        sticky_clr = 1'b1;
        run(45);
        // Reset in the middle of a scan while held
        hold = 1'b1;
        run(13);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hold  = 1'b0;
        run(12);
        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
